// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared control codes, FSM encoding and helpers for the execute unit
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle logic/arithmetic ops and illegal-code detection
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      control_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  logic slt_w;
  assign slt_w = ($signed(a_i) < $signed(b_i));

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (control_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o = {{(XLEN-1){1'b0}}, slt_w};
      // Shifts are legal but iterate in the top level; nothing to compute here.
      ALU_SLL, ALU_SRL, ALU_SRA: result_o = '0;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle execute unit with valid/ready handshakes and iterative shifter
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      control_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;

  logic [XLEN-1:0]   comb_result;
  logic              comb_illegal;
  logic [XLEN-1:0]   shift_next;
  logic [SHW-1:0]    shamt;

  assign shamt = b[SHW-1:0];

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .control_i (control_in),
    .a_i       (a),
    .b_i       (b),
    .result_o  (comb_result),
    .illegal_o (comb_illegal)
  );

  // result_q doubles as the shift register while iterating.
  always_comb begin
    case (op_q)
      ALU_SLL: shift_next = {result_q[XLEN-2:0], 1'b0};
      ALU_SRL: shift_next = {1'b0, result_q[XLEN-1:1]};
      default: shift_next = {result_q[XLEN-1], result_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_shift_op(control_in)) begin
            op_d      = control_in;
            illegal_d = 1'b0;
            result_d  = a;
            if (shamt == '0) begin
              zero_d  = (a == '0);
              state_d = DONE;
            end else begin
              cnt_d   = shamt;
              state_d = SHIFT;
            end
          end else begin
            result_d  = comb_result;
            illegal_d = comb_illegal;
            zero_d    = (comb_result == '0);
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        result_d = shift_next;
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          zero_d  = (shift_next == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      op_q      <= ALU_SLL;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with directed vectors
module tb_alu_exec_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  control_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  logic active;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   hs_cnt   = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .control_in (control_in),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per result and re-checks it every cycle it is held.
  initial active = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      active = 1'b0;
    end else if (out_valid) begin
      if (!active) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          cur    = sbq.pop_front();
          active = 1'b1;
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end
      if (active) begin
        chk("result", result, cur.res);
        chk("zero", {31'd0, zero}, {31'd0, cur.zero});
        chk("illegal", {31'd0, illegal}, {31'd0, cur.ill});
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          active = 1'b0;
          hs_cnt++;
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic ei, input int lat, input int hold);
    exp_t e;
    int   start;
    int   vcnt;
    int   budget;
    @(posedge clk); #1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    control_in = c;
    a          = av;
    b          = bv;
    in_valid   = 1'b1;
    out_ready  = (hold == 0);
    e.res  = er;
    e.zero = (er == 32'd0);
    e.ill  = ei;
    e.lat  = lat;
    e.acc  = cyc;
    sbq.push_back(e);
    start  = hs_cnt;
    vcnt   = 0;
    budget = 0;
    while (budget < 200) begin
      @(posedge clk); #1;
      budget++;
      if (hs_cnt != start) break;
      if (out_valid) begin
        in_valid = 1'b0;
        vcnt++;
        if (vcnt >= hold) out_ready = 1'b1;
      end else begin
        // Busy: present a conflicting request that must be ignored.
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        in_valid   = 1'b1;
        a          = $urandom;
        b          = $urandom;
        control_in = 4'($urandom_range(0, 15));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (hs_cnt == start) begin
      chk("handshake_timeout", 32'd0, 32'd1);
    end else begin
      chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    control_in = 4'd0;
    a          = 32'd0;
    b          = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;

    //     code     a              b              result         ill   lat hold
    run_op(4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1,  0);
    run_op(4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1,  3);
    run_op(4'b0101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5,  0);
    run_op(4'b0101, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 1'b0, 1,  0);
    run_op(4'b0011, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1,  0);
    run_op(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1,  0);
    run_op(4'b1111, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1,  0);
    run_op(4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1,  0);
    run_op(4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1,  0);
    run_op(4'b0100, 32'h8000_0001, 32'hFFFF_FFE3, 32'h1000_0000, 1'b0, 4,  2);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1,  0);
    run_op(4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1,  0);
    run_op(4'b0101, 32'h7000_0000, 32'h0000_0002, 32'h1C00_0000, 1'b0, 3,  0);

    // Reset in the middle of a 20-step shift: no output may ever appear for it.
    @(posedge clk); #1;
    control_in = 4'b0011;
    a          = 32'hFFFF_FFFF;
    b          = 32'd20;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_reset", {30'd0, out_valid, in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_stale_output", {31'd0, out_valid}, 32'd0);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1,  0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
